// File: rtl/hsi_pkg.sv
// Shared types and constants for the HSI colour segmentation slice.
// The state enum, output codes and pipeline depth are shared by the segmenter and its helpers.
package hsi_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        PUBLISH  = 2'd2
    } seg_state_t;

    localparam logic [7:0] SEG_HIT  = 8'hFF;
    localparam logic [7:0] SEG_MISS = 8'h00;
    localparam logic [7:0] SEG_BOX  = 8'h80;

    localparam int SEG_LAT = 2;

    // Inclusive hue window; lo > hi means the window wraps through 0 (e.g. red 240..15).
    function automatic logic hue_in_range(input logic [7:0] h,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        else          return (h >= lo) || (h <= hi);
    endfunction

endpackage

// File: rtl/hsi_range_cmp.sv
// Registered single-window HSI pixel classifier, with hue wrap-around.
// Kept standalone so multi-colour segmenters can instantiate one per window.
module hsi_range_cmp
    import hsi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] h,
    input  logic [7:0] s,
    input  logic [7:0] i,
    input  logic [7:0] h_min,
    input  logic [7:0] h_max,
    input  logic [7:0] s_min,
    input  logic [7:0] i_min,
    input  logic [7:0] i_max,
    output logic       hit
);

    logic hit_c;

    // Thresholds are live every cycle so a mid-frame change affects the very next pixel.
    always_comb begin
        hit_c = de && hue_in_range(h, h_min, h_max) &&
                (s >= s_min) && (i >= i_min) && (i <= i_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit <= 1'b0;
        else        hit <= hit_c;
    end

endmodule

// File: rtl/hsi_color_seg.sv
// Colour-window segmenter: binary mask stream (2-cycle latency) plus per-frame hit count and bounding box.
// Optional macro BOX_OVERLAY_EN draws the last published box border into seg_data as 0x80.
module hsi_color_seg
    import hsi_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int XW     = $clog2(H_DISP),
    parameter int YW     = $clog2(V_DISP),
    parameter int CW     = $clog2(H_DISP * V_DISP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          HSI_hsync,
    input  logic          HSI_vsync,
    input  logic [7:0]    H_data,
    input  logic [7:0]    S_data,
    input  logic [7:0]    I_data,
    input  logic          HSI_de,
    input  logic [7:0]    h_min,
    input  logic [7:0]    h_max,
    input  logic [7:0]    s_min,
    input  logic [7:0]    i_min,
    input  logic [7:0]    i_max,
    output logic          seg_hsync,
    output logic          seg_vsync,
    output logic [7:0]    seg_data,
    output logic          seg_de,
    output logic [XW-1:0] box_xmin,
    output logic [XW-1:0] box_xmax,
    output logic [YW-1:0] box_ymin,
    output logic [YW-1:0] box_ymax,
    output logic [CW-1:0] hit_cnt,
    output logic          box_empty,
    output logic          box_valid
);

    localparam logic [XW-1:0] X_LAST = XW'(H_DISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_DISP - 1);

    seg_state_t state, next_state;

    logic               hit_s1;
    logic [SEG_LAT-1:0] hs_pipe, vs_pipe, de_pipe;
    logic [XW-1:0]      x_cnt, x_s1;
    logic [YW-1:0]      y_cnt, y_s1;
    logic               de_fall, vs_rise_in, vs_rise_s1;
    logic [7:0]         seg_next;

    logic [CW-1:0] acc_cnt,  base_cnt;
    logic [XW-1:0] acc_xmin, acc_xmax, base_xmin, base_xmax;
    logic [YW-1:0] acc_ymin, acc_ymax, base_ymin, base_ymax;

    hsi_range_cmp u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (HSI_de),
        .h     (H_data),
        .s     (S_data),
        .i     (I_data),
        .h_min (h_min),
        .h_max (h_max),
        .s_min (s_min),
        .i_min (i_min),
        .i_max (i_max),
        .hit   (hit_s1)
    );

    // Index 0 is stage 1, the top index drives the seg_* outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
            de_pipe <= '0;
        end else begin
            hs_pipe <= {hs_pipe[SEG_LAT-2:0], HSI_hsync};
            vs_pipe <= {vs_pipe[SEG_LAT-2:0], HSI_vsync};
            de_pipe <= {de_pipe[SEG_LAT-2:0], HSI_de};
        end
    end

    assign seg_hsync  = hs_pipe[SEG_LAT-1];
    assign seg_vsync  = vs_pipe[SEG_LAT-1];
    assign seg_de     = de_pipe[SEG_LAT-1];
    assign de_fall    = de_pipe[0] & ~HSI_de;
    assign vs_rise_in = HSI_vsync & ~vs_pipe[0];
    assign vs_rise_s1 = vs_pipe[0] & ~vs_pipe[1];

    // Coordinates clamp at the last column/row rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            x_s1  <= '0;
            y_s1  <= '0;
        end else begin
            if (!HSI_de)              x_cnt <= '0;
            else if (x_cnt != X_LAST) x_cnt <= x_cnt + 1'b1;
            if (vs_rise_in)                     y_cnt <= '0;
            else if (de_fall && y_cnt != Y_LAST) y_cnt <= y_cnt + 1'b1;
            x_s1 <= x_cnt;
            y_s1 <= y_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_SOF;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_SOF: if (vs_rise_s1) next_state = ACCUM;
            ACCUM:    if (vs_rise_s1) next_state = PUBLISH;
            PUBLISH:  next_state = ACCUM;
            default:  next_state = WAIT_SOF;
        endcase
    end

    // Outside ACCUM the accumulators restart; a hit landing in PUBLISH seeds the new frame.
    always_comb begin
        base_cnt  = '0;
        base_xmin = '1;
        base_xmax = '0;
        base_ymin = '1;
        base_ymax = '0;
        if (state == ACCUM) begin
            base_cnt  = acc_cnt;
            base_xmin = acc_xmin;
            base_xmax = acc_xmax;
            base_ymin = acc_ymin;
            base_ymax = acc_ymax;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
        end else begin
            acc_cnt  <= base_cnt;
            acc_xmin <= base_xmin;
            acc_xmax <= base_xmax;
            acc_ymin <= base_ymin;
            acc_ymax <= base_ymax;
            if (hit_s1 && state != WAIT_SOF) begin
                if (base_cnt != '1)    acc_cnt  <= base_cnt + 1'b1;
                if (x_s1 < base_xmin)  acc_xmin <= x_s1;
                if (x_s1 > base_xmax)  acc_xmax <= x_s1;
                if (y_s1 < base_ymin)  acc_ymin <= y_s1;
                if (y_s1 > base_ymax)  acc_ymax <= y_s1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_xmin  <= '0;
            box_xmax  <= '0;
            box_ymin  <= '0;
            box_ymax  <= '0;
            hit_cnt   <= '0;
            box_empty <= 1'b0;
            box_valid <= 1'b0;
        end else begin
            box_valid <= 1'b0;
            if (state == PUBLISH) begin
                box_valid <= 1'b1;
                hit_cnt   <= acc_cnt;
                box_empty <= (acc_cnt == '0);
                if (acc_cnt == '0) begin
                    box_xmin <= '0;
                    box_xmax <= '0;
                    box_ymin <= '0;
                    box_ymax <= '0;
                end else begin
                    box_xmin <= acc_xmin;
                    box_xmax <= acc_xmax;
                    box_ymin <= acc_ymin;
                    box_ymax <= acc_ymax;
                end
            end
        end
    end

`ifdef BOX_OVERLAY_EN
    logic on_border;
    assign on_border =
        ((x_s1 == box_xmin || x_s1 == box_xmax) && y_s1 >= box_ymin && y_s1 <= box_ymax) ||
        ((y_s1 == box_ymin || y_s1 == box_ymax) && x_s1 >= box_xmin && x_s1 <= box_xmax);

    always_comb begin
        seg_next = hit_s1 ? SEG_HIT : SEG_MISS;
        if (de_pipe[0] && !box_empty && on_border) seg_next = SEG_BOX;
    end
`else
    always_comb begin
        seg_next = hit_s1 ? SEG_HIT : SEG_MISS;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_data <= SEG_MISS;
        else        seg_data <= seg_next;
    end

endmodule
